// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs_pkg
//  Description : Shared constants for the 5-stage MIPS pipeline: datapath
//                width, NOP encoding, HALT opcode and IF-stage FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_defs_pkg;

  localparam int          NBITS       = 32;
  localparam logic [31:0] NOP         = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  // Fetch-stage run control states; 2'd3 is unreachable and recovers to IDLE
  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RUN      = 2'd1;
  localparam logic [1:0]  ST_HALT     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Priority: reset, hold, flush (NOP),
//                load. The same pattern is reused for later stage registers.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
  import mips_defs_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Hold,
  input  logic             i_Flush,
  input  logic [NBITS-1:0] i_Instr,
  input  logic [NBITS-1:0] i_PC4,
  output logic [NBITS-1:0] o_Instr,
  output logic [NBITS-1:0] o_PC4
);

  logic [NBITS-1:0] instr_q;
  logic [NBITS-1:0] pc4_q;

  // Stage register: hold keeps contents, flush inserts a NOP bubble
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instr_q <= NBITS'(NOP);
      pc4_q   <= '0;
    end else if (i_Hold) begin
      instr_q <= instr_q;
      pc4_q   <= pc4_q;
    end else if (i_Flush) begin
      instr_q <= NBITS'(NOP);
      pc4_q   <= '0;
    end else begin
      instr_q <= i_Instr;
      pc4_q   <= i_PC4;
    end
  end

  assign o_Instr = instr_q;
  assign o_PC4   = pc4_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_stage
//  Description : IF stage: program counter, PC+4 adder, IF/ID register,
//                HALT detection and the debug run/step/halt FSM that gates
//                pipeline advance and counts enabled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_stage
  import mips_defs_pkg::*;
#(
  parameter int         NBITS       = 32,
  parameter int         NBITS_CNT   = 32,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NBITS-1:0]     i_PC_Next,
  input  logic [NBITS-1:0]     i_Instr,
  input  logic                 i_Stall,
  input  logic                 i_Flush,
  input  logic                 i_Run,
  input  logic                 i_Step,
  output logic [NBITS-1:0]     o_PC,
  output logic [NBITS-1:0]     o_PC4,
  output logic [NBITS-1:0]     o_IFID_Instr,
  output logic [NBITS-1:0]     o_IFID_PC4,
  output logic                 o_Enable,
  output logic                 o_Halted,
  output logic [NBITS_CNT-1:0] o_Cycles
);

  logic [1:0]           state_q, state_d;
  logic [NBITS-1:0]     pc_q, pc_d;
  logic [NBITS_CNT-1:0] cycles_q, cycles_d;
  logic                 enable;
  logic                 halt_fetch;
  logic                 in_halt;
  logic                 ifid_hold;
  logic                 ifid_flush;

  assign halt_fetch = (i_Instr[NBITS-1 -: 6] == HALT_OPCODE);
  assign in_halt    = (state_q == ST_HALT);
  assign o_PC4      = pc_q + NBITS'(4);
  assign o_PC       = pc_q;
  assign o_Cycles   = cycles_q;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: a HALT fetched on an enabled, unstalled, unflushed
  // cycle ends the run from either IDLE (step) or RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !i_Stall && !i_Flush && halt_fetch) state_d = ST_HALT;
        else if (i_Run)                                   state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_Stall && !i_Flush && halt_fetch) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: HALT keeps the pipeline enabled so downstream stages drain
  always_comb begin
    enable   = 1'b0;
    o_Halted = 1'b0;
    case (state_q)
      ST_IDLE: enable = i_Step | i_Run;
      ST_RUN:  enable = 1'b1;
      ST_HALT: begin
        enable   = 1'b1;
        o_Halted = 1'b1;
      end
      default: enable = 1'b0;
    endcase
  end

  assign o_Enable = enable;

  // PC next value: stall holds, flush redirects, HALT freezes the PC
  always_comb begin
    pc_d = pc_q;
    if (enable && !in_halt && !i_Stall && (i_Flush || !halt_fetch))
      pc_d = i_PC_Next;
  end

  // PC register
  always_ff @(posedge i_clk) begin
    if (i_reset) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  // Enabled-cycle counter, saturating at all-ones
  always_comb begin
    cycles_d = cycles_q;
    if (enable && (cycles_q != '1))
      cycles_d = cycles_q + NBITS_CNT'(1);
  end

  // Cycle counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  // IF/ID controls: stall beats flush; HALT state feeds NOPs every cycle
  assign ifid_hold  = ~enable | (~in_halt & i_Stall);
  assign ifid_flush = in_halt | i_Flush;

  if_id_reg #(
    .NBITS (NBITS)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_Hold  (ifid_hold),
    .i_Flush (ifid_flush),
    .i_Instr (i_Instr),
    .i_PC4   (o_PC4),
    .o_Instr (o_IFID_Instr),
    .o_PC4   (o_IFID_PC4)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_stage
//  Description : Directed self-checking bench for pc_fetch_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_PC_Next;
  logic [31:0] i_Instr;
  logic        i_Stall, i_Flush, i_Run, i_Step;
  logic [31:0] o_PC, o_PC4, o_IFID_Instr, o_IFID_PC4, o_Cycles;
  logic        o_Enable, o_Halted;

  logic        use_pc4;
  logic [31:0] pc_next_drv;
  int          n_total = 0;
  int          n_pass  = 0;

  localparam logic [31:0] I_ADD  = 32'h2000_0001;
  localparam logic [31:0] I_ADD2 = 32'h2400_0002;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  always #5 i_clk = ~i_clk;

  assign i_PC_Next = use_pc4 ? o_PC4 : pc_next_drv;

  pc_fetch_stage #(
    .NBITS       (32),
    .NBITS_CNT   (32),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_PC_Next    (i_PC_Next),
    .i_Instr      (i_Instr),
    .i_Stall      (i_Stall),
    .i_Flush      (i_Flush),
    .i_Run        (i_Run),
    .i_Step       (i_Step),
    .o_PC         (o_PC),
    .o_PC4        (o_PC4),
    .o_IFID_Instr (o_IFID_Instr),
    .o_IFID_PC4   (o_IFID_PC4),
    .o_Enable     (o_Enable),
    .o_Halted     (o_Halted),
    .o_Cycles     (o_Cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One rising edge, then return on the falling edge for sampling/driving
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_Instr = I_ADD; i_Stall = 1'b0; i_Flush = 1'b0;
    i_Run = 1'b0; i_Step = 1'b0; use_pc4 = 1'b1; pc_next_drv = '0;
    tick();
    check("rst_pc",      o_PC,         32'h0);
    check("rst_ifid_in", o_IFID_Instr, 32'h0);
    check("rst_ifid_p4", o_IFID_PC4,   32'h0);
    check("rst_cycles",  o_Cycles,     32'h0);
    check("rst_halted",  {31'b0, o_Halted}, 32'h0);
    i_reset = 1'b0;
    #1 check("idle_en0", {31'b0, o_Enable}, 32'h0);

    // Sequential run: PC 0 -> 4 -> 8 -> C
    i_Run = 1'b1;
    #1 check("idle_run_en", {31'b0, o_Enable}, 32'h1);
    tick();
    check("run_pc1",      o_PC,         32'h4);
    check("run_ifid_p4",  o_IFID_PC4,   32'h4);
    check("run_ifid_in",  o_IFID_Instr, I_ADD);
    i_Run = 1'b0;
    tick();
    check("run_pc2", o_PC, 32'h8);
    tick();
    check("run_pc3",     o_PC,     32'hC);
    check("run_cycles3", o_Cycles, 32'd3);

    // Stall two cycles at PC=C, then stall+flush together
    i_Stall = 1'b1; i_Instr = I_ADD2;
    tick(); tick();
    check("stall_pc",     o_PC,         32'hC);
    check("stall_ifid",   o_IFID_PC4,   32'hC);
    check("stall_cycles", o_Cycles,     32'd5);
    i_Flush = 1'b1; use_pc4 = 1'b0; pc_next_drv = 32'h80;
    tick();
    check("stfl_pc",   o_PC,         32'hC);
    check("stfl_ifid", o_IFID_Instr, I_ADD);
    i_Stall = 1'b0; i_Flush = 1'b0; use_pc4 = 1'b1;
    tick();
    check("rel_pc",      o_PC,         32'h10);
    check("rel_ifid_in", o_IFID_Instr, I_ADD2);
    check("rel_ifid_p4", o_IFID_PC4,   32'h10);
    check("rel_cycles",  o_Cycles,     32'd7);

    // Flush redirect to 0x40
    i_Flush = 1'b1; use_pc4 = 1'b0; pc_next_drv = 32'h40; i_Instr = I_ADD;
    tick();
    check("fl_pc",      o_PC,         32'h40);
    check("fl_ifid_in", o_IFID_Instr, 32'h0);
    check("fl_ifid_p4", o_IFID_PC4,   32'h0);

    // HALT in a branch shadow is discarded
    i_Instr = I_HALT; pc_next_drv = 32'h10;
    tick();
    check("hfl_halted", {31'b0, o_Halted}, 32'h0);
    check("hfl_pc",     o_PC,         32'h10);
    check("hfl_ifid",   o_IFID_Instr, 32'h0);

    // Real HALT at PC 0x10
    i_Flush = 1'b0; pc_next_drv = 32'h99;
    tick();
    check("h_ifid_in", o_IFID_Instr, I_HALT);
    check("h_ifid_p4", o_IFID_PC4,   32'h14);
    check("h_pc",      o_PC,         32'h10);
    check("h_halted",  {31'b0, o_Halted}, 32'h1);
    check("h_cycles",  o_Cycles,     32'd10);
    i_Run = 1'b1; i_Step = 1'b1; i_Instr = I_ADD;
    tick();
    check("h2_ifid",   o_IFID_Instr, 32'h0);
    check("h2_pc",     o_PC,         32'h10);
    check("h2_halted", {31'b0, o_Halted}, 32'h1);
    check("h2_en",     {31'b0, o_Enable}, 32'h1);
    check("h2_cycles", o_Cycles,     32'd11);
    i_Run = 1'b0; i_Step = 1'b0; i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    #1;
    check("hr_pc",     o_PC,         32'h0);
    check("hr_halted", {31'b0, o_Halted}, 32'h0);
    check("hr_en",     {31'b0, o_Enable}, 32'h0);
    check("hr_cycles", o_Cycles,     32'h0);

    // Step mode: three pulses separated by idle cycles
    use_pc4 = 1'b1;
    @(negedge i_clk);
    for (int k = 1; k <= 3; k++) begin
      i_Step = 1'b1;
      #1 check("step_en", {31'b0, o_Enable}, 32'h1);
      tick();
      i_Step = 1'b0;
      #1 check("step_pc", o_PC, 32'(4 * k));
      check("step_en0", {31'b0, o_Enable}, 32'h0);
      tick();
      check("step_hold", o_PC, 32'(4 * k));
    end
    check("step_cycles", o_Cycles, 32'd3);

    // Run and step together: one enabled cycle, then in RUN
    i_Run = 1'b1; i_Step = 1'b1;
    tick();
    check("rs_pc",     o_PC,     32'h10);
    check("rs_cycles", o_Cycles, 32'd4);
    i_Run = 1'b0; i_Step = 1'b0;
    tick();
    check("rs_run_pc",  o_PC,     32'h14);
    check("rs_cycles2", o_Cycles, 32'd5);

    // PC+4 wraps at the top of the address space
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0; i_Run = 1'b1; i_Flush = 1'b1; use_pc4 = 1'b0;
    pc_next_drv = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc",  o_PC,  32'hFFFF_FFFC);
    check("wrap_pc4", o_PC4, 32'h0);
    i_Flush = 1'b0; use_pc4 = 1'b1;
    tick();
    check("wrap_next",    o_PC,       32'h0);
    check("wrap_ifid_p4", o_IFID_PC4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
